// File: rtl/gray_pointer_receiver.sv
// Receive-side endpoint for a synchronized Gray pointer: decode, step report, occupancy.
// Optional multi-bit-transition checker enabled by GRAY_POINTER_RECEIVER_CHECK_EN.
`default_nettype none

module gray_pointer_receiver #(
  parameter int LENGTH = 8
) (
  input  logic              clk_diff,
  input  logic              reset_diff_n,
  input  logic [LENGTH-1:0] gray_in,
  input  logic [LENGTH-1:0] local_ptr,
  input  logic              error_clear,
  output logic [LENGTH-1:0] binary_out,
  output logic              step_valid,
  output logic [LENGTH-1:0] step_count,
  output logic [LENGTH-1:0] level,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              gray_error,
  output logic [LENGTH-1:0] error_gray
);

  localparam logic [LENGTH-1:0] HALF = {1'b1, {(LENGTH-1){1'b0}}};

  logic [LENGTH-1:0] gray_q;
  logic              sample_valid_q;
  logic              init_done_q;
  logic [LENGTH-1:0] binary_out_q;
  logic              step_valid_q;
  logic [LENGTH-1:0] step_count_q;
  logic [LENGTH-1:0] level_q;
  logic              empty_q;
  logic              full_q;
  logic              overrun_q;

  logic [LENGTH-1:0] bin_next_d;
  logic [LENGTH-1:0] step_d;
  logic [LENGTH-1:0] level_d;

  always_comb begin
    bin_next_d = '0;
    for (int i = 0; i < LENGTH; i++) begin
      bin_next_d[i] = ^(gray_q >> i);
    end
    step_d  = bin_next_d - binary_out_q;
    level_d = binary_out_q - local_ptr;
  end

  // gray_q only holds a real sample one edge after reset release, so the
  // init load waits for sample_valid_q rather than decoding the reset value.
  always_ff @(posedge clk_diff or negedge reset_diff_n) begin
    if (!reset_diff_n) begin
      gray_q         <= '0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      binary_out_q   <= '0;
      step_valid_q   <= 1'b0;
      step_count_q   <= '0;
      level_q        <= '0;
      empty_q        <= 1'b0;
      full_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      gray_q         <= gray_in;
      sample_valid_q <= 1'b1;
      step_valid_q   <= 1'b0;
      if (sample_valid_q) begin
        binary_out_q <= bin_next_d;
        if (!init_done_q) begin
          init_done_q <= 1'b1;
        end else begin
          step_count_q <= step_d;
          step_valid_q <= (bin_next_d != binary_out_q);
        end
      end
      level_q   <= level_d;
      empty_q   <= (level_d == '0);
      full_q    <= (level_d == HALF);
      overrun_q <= (level_d > HALF);
    end
  end

`ifdef GRAY_POINTER_RECEIVER_CHECK_EN
  logic [LENGTH-1:0] gray_prev_q;
  logic              gray_error_q;
  logic [LENGTH-1:0] error_gray_q;
  logic [LENGTH-1:0] gray_diff_d;
  logic              multi_bit_d;

  // More than one set bit <=> clearing the lowest set bit leaves something.
  always_comb begin
    gray_diff_d = gray_q ^ gray_prev_q;
    multi_bit_d = init_done_q && ((gray_diff_d & (gray_diff_d - 1'b1)) != '0);
  end

  always_ff @(posedge clk_diff or negedge reset_diff_n) begin
    if (!reset_diff_n) begin
      gray_prev_q  <= '0;
      gray_error_q <= 1'b0;
      error_gray_q <= '0;
    end else begin
      if (sample_valid_q) begin
        gray_prev_q <= gray_q;
      end
      if (multi_bit_d) begin
        gray_error_q <= 1'b1;
        if (!gray_error_q || error_clear) begin
          error_gray_q <= gray_q;
        end
      end else if (error_clear) begin
        gray_error_q <= 1'b0;
        error_gray_q <= '0;
      end
    end
  end

  assign gray_error = gray_error_q;
  assign error_gray = error_gray_q;
`else
  logic unused_error_clear;
  assign unused_error_clear = error_clear;
  assign gray_error         = 1'b0;
  assign error_gray         = '0;
`endif

  assign binary_out = binary_out_q;
  assign step_valid = step_valid_q;
  assign step_count = step_count_q;
  assign level      = level_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
